// File: rtl/n64_bus_dispatch.sv
// n64_bus_dispatch: routes single-outstanding PI bus requests to one device by ID.
// Returns ack/rdata upstream. A per-access timeout guards against hung devices.
// Optional feature macro N64_BUS_PREFETCH_EN enables a 1-word sequential SDRAM read prefetch buffer.
// Handshake: up_request, dev_request, dev_ack and up_ack are single-cycle pulses. Only one access is in flight at a time.
// dev_write, dev_address and dev_wdata are held stable from dev_request until that access completes.
module n64_bus_dispatch #(
    parameter int NUM_DEV        = 5,
    parameter int ID_W           = 3,
    parameter int SDRAM_ID       = 1,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  up_request,
    input  logic                  up_write,
    input  logic [ID_W-1:0]       up_id,
    input  logic [31:0]           up_address,
    input  logic [15:0]           up_wdata,
    output logic                  up_ack,
    output logic [15:0]           up_rdata,
    output logic [NUM_DEV-1:0]    dev_request,
    output logic                  dev_write,
    output logic [31:0]           dev_address,
    output logic [15:0]           dev_wdata,
    input  logic [NUM_DEV-1:0]    dev_ack,
    input  logic [NUM_DEV*16-1:0] dev_rdata,
    input  logic                  flush,
    input  logic                  clear_error,
    output logic                  timeout_error,
    output logic                  unmapped_error,
    output logic [1:0]            dbg_state
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [ID_W-1:0]  SD_ID   = ID_W'(SDRAM_ID);
`ifdef N64_BUS_PREFETCH_EN
    localparam logic PF_EN = 1'b1;
`else
    localparam logic PF_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_PREFETCH = 2'd2} state_t;

    state_t           state, nstate;
    logic [CNT_W-1:0] cnt;
    logic [ID_W-1:0]  cur_id;
    logic             pf_valid, pf_discard;
    logic [31:0]      pf_tag;
    logic [15:0]      pf_data;
    logic             pend_valid, pend_write;
    logic [ID_W-1:0]  pend_id;
    logic [31:0]      pend_addr;
    logic [15:0]      pend_wdata;

    logic             req_valid, req_write, req_unmapped;
    logic [ID_W-1:0]  req_id;
    logic [31:0]      req_addr;
    logic [15:0]      req_wdata;
    logic             sel_ack;
    logic [15:0]      sel_rdata;
    logic             flush_eff;

    logic             launch, l_write;
    logic [ID_W-1:0]  l_id;
    logic [31:0]      l_addr;
    logic [15:0]      l_wdata;
    logic             ack_now;
    logic [15:0]      ack_data;
    logic             set_unmapped, set_timeout;
    logic             pf_fill, pf_kill, pend_take, pend_consume;

    assign dbg_state = state;
    assign flush_eff = flush & PF_EN;

    // A held pending request takes priority over the upstream port when idle.
    assign req_valid    = (state == S_IDLE) && (pend_valid || up_request);
    assign req_write    = pend_valid ? pend_write : up_write;
    assign req_id       = pend_valid ? pend_id    : up_id;
    assign req_addr     = pend_valid ? pend_addr  : up_address;
    assign req_wdata    = pend_valid ? pend_wdata : up_wdata;
    assign req_unmapped = ({1'b0, req_id} >= (ID_W+1)'(NUM_DEV));
    assign sel_ack      = dev_ack[cur_id];
    assign sel_rdata    = dev_rdata[16*cur_id +: 16];

    // Next-state and per-cycle control decisions.
    always_comb begin
        nstate       = state;
        launch       = 1'b0;
        l_id         = cur_id;
        l_addr       = dev_address;
        l_write      = dev_write;
        l_wdata      = dev_wdata;
        ack_now      = 1'b0;
        ack_data     = 16'hFFFF;
        set_unmapped = 1'b0;
        set_timeout  = 1'b0;
        pf_fill      = 1'b0;
        pf_kill      = 1'b0;
        pend_take    = 1'b0;
        pend_consume = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    pend_consume = pend_valid;
                    if (req_unmapped) begin
                        ack_now      = 1'b1;
                        set_unmapped = 1'b1;
                    end else if (PF_EN && req_id == SD_ID && !req_write && pf_valid && req_addr == pf_tag) begin
                        // Buffer hit: answer now, then fetch the following word.
                        ack_now  = 1'b1;
                        ack_data = pf_data;
                        launch   = 1'b1;
                        l_id     = SD_ID;
                        l_addr   = pf_tag + 32'd2;
                        l_write  = 1'b0;
                        pf_kill  = 1'b1;
                        nstate   = S_PREFETCH;
                    end else begin
                        launch  = 1'b1;
                        l_id    = req_id;
                        l_addr  = req_addr;
                        l_write = req_write;
                        l_wdata = req_wdata;
                        pf_kill = (req_id == SD_ID) && req_write;
                        nstate  = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (sel_ack) begin
                    ack_now  = 1'b1;
                    ack_data = sel_rdata;
                    if (PF_EN && cur_id == SD_ID && !dev_write) begin
                        launch  = 1'b1;
                        l_id    = SD_ID;
                        l_addr  = dev_address + 32'd2;
                        l_write = 1'b0;
                        pf_kill = 1'b1;
                        nstate  = S_PREFETCH;
                    end else begin
                        nstate = S_IDLE;
                    end
                end else if (cnt == CNT_MAX) begin
                    ack_now     = 1'b1;
                    set_timeout = 1'b1;
                    nstate      = S_IDLE;
                end
            end
            S_PREFETCH: begin
                pend_take = up_request && !pend_valid;
                if (sel_ack) begin
                    pf_fill = 1'b1;
                    nstate  = S_IDLE;
                end else if (cnt == CNT_MAX) begin
                    set_timeout = 1'b1;
                    nstate      = S_IDLE;
                end
            end
            default: nstate = S_IDLE;
        endcase
    end

    // State, datapath and buffer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            cnt            <= '0;
            cur_id         <= '0;
            up_ack         <= 1'b0;
            up_rdata       <= '0;
            dev_request    <= '0;
            dev_write      <= 1'b0;
            dev_address    <= '0;
            dev_wdata      <= '0;
            timeout_error  <= 1'b0;
            unmapped_error <= 1'b0;
            pf_valid       <= 1'b0;
            pf_discard     <= 1'b0;
            pf_tag         <= '0;
            pf_data        <= '0;
            pend_valid     <= 1'b0;
            pend_write     <= 1'b0;
            pend_id        <= '0;
            pend_addr      <= '0;
            pend_wdata     <= '0;
        end else begin
            state          <= nstate;
            up_ack         <= ack_now;
            if (ack_now) up_rdata <= ack_data;
            dev_request    <= launch ? (NUM_DEV'(1) << l_id) : '0;
            if (launch) begin
                cur_id      <= l_id;
                dev_write   <= l_write;
                dev_address <= l_addr;
                dev_wdata   <= l_wdata;
                cnt         <= '0;
            end else if (state != S_IDLE) begin
                cnt <= cnt + 1'b1;
            end
            timeout_error  <= set_timeout  | (timeout_error  & ~clear_error);
            unmapped_error <= set_unmapped | (unmapped_error & ~clear_error);
            // Flush or a competing write beats a fill; a flushed in-flight prefetch is discarded.
            if (flush_eff || pf_kill) begin
                pf_valid <= 1'b0;
            end else if (pf_fill && !pf_discard) begin
                pf_valid <= 1'b1;
                pf_tag   <= dev_address;
                pf_data  <= sel_rdata;
            end
            if (flush_eff) pf_discard <= 1'b1;
            else if (launch && nstate == S_PREFETCH) pf_discard <= 1'b0;
            if (pend_take) begin
                pend_valid <= 1'b1;
                pend_write <= up_write;
                pend_id    <= up_id;
                pend_addr  <= up_address;
                pend_wdata <= up_wdata;
            end else if (pend_consume) begin
                pend_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_n64_bus_dispatch.sv
// tb_n64_bus_dispatch: directed-vector bench for n64_bus_dispatch.
// Prefetch vectors are compiled in when N64_BUS_PREFETCH_EN is defined.
module tb_n64_bus_dispatch;
    localparam int TIMEOUT = 1023;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        up_request, up_write;
    logic [2:0]  up_id;
    logic [31:0] up_address;
    logic [15:0] up_wdata;
    logic        up_ack;
    logic [15:0] up_rdata;
    logic [4:0]  dev_request;
    logic        dev_write;
    logic [31:0] dev_address;
    logic [15:0] dev_wdata;
    logic [4:0]  dev_ack;
    logic [79:0] dev_rdata;
    logic        flush, clear_error;
    logic        timeout_error, unmapped_error;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int n;

    n64_bus_dispatch #(.NUM_DEV(5), .ID_W(3), .SDRAM_ID(1), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .up_request(up_request), .up_write(up_write), .up_id(up_id),
        .up_address(up_address), .up_wdata(up_wdata),
        .up_ack(up_ack), .up_rdata(up_rdata),
        .dev_request(dev_request), .dev_write(dev_write),
        .dev_address(dev_address), .dev_wdata(dev_wdata),
        .dev_ack(dev_ack), .dev_rdata(dev_rdata),
        .flush(flush), .clear_error(clear_error),
        .timeout_error(timeout_error), .unmapped_error(unmapped_error),
        .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_request(input logic wr, input logic [2:0] id, input logic [31:0] addr,
                              input logic [15:0] wd);
        up_request = 1'b1;
        up_write   = wr;
        up_id      = id;
        up_address = addr;
        up_wdata   = wd;
        tick();
        up_request = 1'b0;
    endtask

    task automatic dev_respond(input int idx, input logic [15:0] data);
        dev_ack = '0;
        dev_ack[idx] = 1'b1;
        dev_rdata[16*idx +: 16] = data;
        tick();
        dev_ack = '0;
    endtask

    task automatic wait_ack(input int max_cycles, output int cycles);
        cycles = 0;
        while (!up_ack && cycles < max_cycles) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        reset_n = 1'b0; up_request = 1'b0; up_write = 1'b0; up_id = '0;
        up_address = '0; up_wdata = '0; dev_ack = '0; dev_rdata = '0;
        flush = 1'b0; clear_error = 1'b0;
        repeat (3) tick();
        check("rst_up_ack", up_ack, 0);
        check("rst_dev_request", dev_request, 0);
        check("rst_dev_address", dev_address, 0);
        check("rst_errors", {timeout_error, unmapped_error}, 0);
        check("rst_state", dbg_state, 0);
        reset_n = 1'b1;
        tick();

        // 1: read id0, device acks 3 cycles after dev_request
        do_request(1'b0, 3'd0, 32'h1000_0000, 16'h0);
        check("t1_dev_request", dev_request, 5'b00001);
        check("t1_dev_address", dev_address, 32'h1000_0000);
        check("t1_dev_write", dev_write, 0);
        tick(); tick();
        check("t1_dev_req_pulse", dev_request, 0);
        tick();
        check("t1_no_early_ack", up_ack, 0);
        check("t1_addr_held", dev_address, 32'h1000_0000);
        dev_respond(0, 16'hBEEF);
        check("t1_up_ack", up_ack, 1);
        check("t1_up_rdata", up_rdata, 16'hBEEF);
        tick();
        check("t1_ack_pulse", up_ack, 0);
        check("t1_rdata_held", up_rdata, 16'hBEEF);

        // Non-selected ack and an up_request during S_WAIT are both ignored
        do_request(1'b0, 3'd3, 32'h0300_0010, 16'h0);
        check("ign_dev_request", dev_request, 5'b01000);
        do_request(1'b0, 3'd0, 32'h0000_1000, 16'h0);
        check("ign_wait_req", {up_ack, dev_request}, 0);
        dev_respond(4, 16'h9999);
        check("ign_other_ack", up_ack, 0);
        dev_respond(3, 16'h5A5A);
        check("ign_sel_ack", up_ack, 1);
        check("ign_sel_rdata", up_rdata, 16'h5A5A);
        tick();
        check("ign_single_ack", {up_ack, dev_request}, 0);

        // 2: write id2, device never acks
        do_request(1'b1, 3'd2, 32'h0500_0000, 16'h1234);
        check("t2_dev_request", dev_request, 5'b00100);
        check("t2_dev_write", dev_write, 1);
        check("t2_dev_wdata", dev_wdata, 16'h1234);
        wait_ack(TIMEOUT + 50, n);
        check("t2_up_ack", up_ack, 1);
        check("t2_latency", n, TIMEOUT + 1);
        check("t2_rdata", up_rdata, 16'hFFFF);
        check("t2_timeout_error", timeout_error, 1);
        tick(); tick();
        check("t2_error_sticky", timeout_error, 1);
        dev_respond(2, 16'h7777);
        check("t2_stray_ack", up_ack, 0);
        clear_error = 1'b1;
        tick();
        clear_error = 1'b0;
        check("t2_cleared", timeout_error, 0);

        // 3: unmapped id
        do_request(1'b0, 3'd6, 32'h0000_0000, 16'h0);
        check("t3_up_ack", up_ack, 1);
        check("t3_rdata", up_rdata, 16'hFFFF);
        check("t3_unmapped", unmapped_error, 1);
        check("t3_no_dev_req", dev_request, 0);
        check("t3_state", dbg_state, 0);
        clear_error = 1'b1;
        do_request(1'b0, 3'd7, 32'h0000_0000, 16'h0);
        clear_error = 1'b0;
        check("t3_error_wins", unmapped_error, 1);
        clear_error = 1'b1;
        tick();
        clear_error = 1'b0;
        check("t3_cleared", unmapped_error, 0);

`ifdef N64_BUS_PREFETCH_EN
        // 4: sequential SDRAM reads, second served from buffer
        do_request(1'b0, 3'd1, 32'h0000_0100, 16'h0);
        check("t4_dev_request", dev_request, 5'b00010);
        dev_respond(1, 16'hAAAA);
        check("t4_ack1", up_ack, 1);
        check("t4_rdata1", up_rdata, 16'hAAAA);
        check("t4_pf_req", dev_request, 5'b00010);
        check("t4_pf_addr", dev_address, 32'h0000_0102);
        dev_respond(1, 16'hBBBB);
        check("t4_pf_no_ack", up_ack, 0);
        do_request(1'b0, 3'd1, 32'h0000_0102, 16'h0);
        check("t4_hit_ack", up_ack, 1);
        check("t4_hit_rdata", up_rdata, 16'hBBBB);
        check("t4_next_pf_addr", dev_address, 32'h0000_0104);
        check("t4_next_pf_req", dev_request, 5'b00010);
        dev_respond(1, 16'hCCCC);

        // 5: request during prefetch held pending, then write invalidates
        do_request(1'b0, 3'd1, 32'h0000_0100, 16'h0);
        check("t5_miss_req", dev_request, 5'b00010);
        dev_respond(1, 16'h1111);
        check("t5_ack1", up_rdata, 16'h1111);
        do_request(1'b0, 3'd1, 32'h0000_0102, 16'h0);
        check("t5_pending_quiet", {up_ack, dev_request}, 0);
        dev_respond(1, 16'h2222);
        wait_ack(4, n);
        check("t5_pend_ack", up_ack, 1);
        check("t5_pend_rdata", up_rdata, 16'h2222);
        check("t5_pend_pf_addr", dev_address, 32'h0000_0104);
        dev_respond(1, 16'h3333);
        do_request(1'b1, 3'd1, 32'h0000_0200, 16'h5555);
        check("t5_wr_req", dev_request, 5'b00010);
        dev_respond(1, 16'h0000);
        check("t5_wr_ack", up_ack, 1);
        check("t5_wr_no_pf", dev_request, 0);
        do_request(1'b0, 3'd1, 32'h0000_0104, 16'h0);
        check("t5_after_wr_dev", dev_request, 5'b00010);
        check("t5_after_wr_noack", up_ack, 0);
        dev_respond(1, 16'h4444);
        check("t5_after_wr_rdata", up_rdata, 16'h4444);
        // Flush while prefetch of 0x106 is in flight discards it
        flush = 1'b1;
        tick();
        flush = 1'b0;
        dev_respond(1, 16'h6666);
        do_request(1'b0, 3'd1, 32'h0000_0106, 16'h0);
        check("flush_miss_req", dev_request, 5'b00010);
        check("flush_miss_noack", up_ack, 0);
        dev_respond(1, 16'h6767);
        check("flush_miss_rdata", up_rdata, 16'h6767);
        dev_respond(1, 16'h0000);

        // Prefetch address wraps at the top of the 32-bit space
        do_request(1'b0, 3'd1, 32'hFFFF_FFFE, 16'h0);
        dev_respond(1, 16'h0F0F);
        check("wrap_pf_addr", dev_address, 32'h0000_0000);
        dev_respond(1, 16'h0000);
`else
        // Without prefetch every SDRAM read goes to the device
        do_request(1'b0, 3'd1, 32'h0000_0100, 16'h0);
        check("np_req1", dev_request, 5'b00010);
        dev_respond(1, 16'hAAAA);
        check("np_ack1", up_rdata, 16'hAAAA);
        check("np_no_pf", dev_request, 0);
        do_request(1'b0, 3'd1, 32'h0000_0102, 16'h0);
        check("np_req2", dev_request, 5'b00010);
        check("np_addr2", dev_address, 32'h0000_0102);
        check("np_noack2", up_ack, 0);
        dev_respond(1, 16'hBBBB);
        check("np_ack2", up_rdata, 16'hBBBB);
`endif

        // 6: reset during S_WAIT
        do_request(1'b0, 3'd6, 32'h0000_0000, 16'h0);
        do_request(1'b0, 3'd0, 32'h1000_0040, 16'h0);
        check("t6_in_wait", dbg_state, 1);
        #2 reset_n = 1'b0;
        #1;
        check("t6_outputs", {up_ack, up_rdata, dev_request, dev_write, dev_wdata}, 0);
        check("t6_address", dev_address, 0);
        check("t6_errors", {timeout_error, unmapped_error}, 0);
        check("t6_state", dbg_state, 0);
        tick();
        reset_n = 1'b1;
        tick();
        dev_respond(0, 16'hDEAD);
        check("t6_no_ack", up_ack, 0);
        tick();
        check("t6_still_no_ack", up_ack, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
